// File: rtl/median3_stream_filter_pkg.sv
// median3_stream_filter_pkg
//   Shared definitions for the 3-tap streaming median filter:
//   default widths, the window fill-state encoding and a reference
//   middle-of-three function on the default sample width.
package median3_stream_filter_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // Number of valid samples currently held in the sliding window.
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_TWO   = 2'd2,
    FILL_FULL  = 2'd3
  } fill_t;

  // Unsigned middle value of three; ties return the tied value.
  function automatic logic [DATA_W_DEF-1:0] median3(
    input logic [DATA_W_DEF-1:0] a,
    input logic [DATA_W_DEF-1:0] b,
    input logic [DATA_W_DEF-1:0] c
  );
    logic [DATA_W_DEF-1:0] res;
    if (((a >= b) && (b >= c)) || ((c >= b) && (b >= a))) begin
      res = b;
    end else if (((b >= a) && (a >= c)) || ((c >= a) && (a >= b))) begin
      res = a;
    end else begin
      res = c;
    end
    return res;
  endfunction

endpackage

// File: rtl/median3_stream_filter_core.sv
// median3_core
//   Purely combinational unsigned middle-of-three selector.
//   Ports:
//     a, b, c : DATA_W-bit unsigned operands
//     med     : DATA_W-bit middle value (a tied value when operands tie)
module median3_core #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] med
);

  logic a_ge_b;
  logic b_ge_c;
  logic a_ge_c;

  assign a_ge_b = (a >= b);
  assign b_ge_c = (b >= c);
  assign a_ge_c = (a >= c);

  // Three comparators are enough: b is the middle when both b-relations
  // agree in direction, a is the middle when a sits between b and c,
  // otherwise c is.
  always_comb begin
    med = c;
    if ((a_ge_b && b_ge_c) || (!a_ge_b && !b_ge_c) ||
        (a == b) || (b == c)) begin
      med = b;
    end else if ((!a_ge_b && a_ge_c) || (a_ge_b && !a_ge_c) || (a == c)) begin
      med = a;
    end
  end

endmodule

// File: rtl/median3_stream_filter.sv
// median3_stream_filter
//   Streaming 3-tap median filter. Keeps a sliding window of the last two
//   accepted samples (w0 newest) plus an extra history tap (w2), feeds
//   median3_core with (in_data, w0, w1) and registers the median into a
//   valid/ready output stream. The window restarts at every in_last.
//
//   Build option:
//     MEDIAN_EDGE_REPLICATE_EN - the first sample of a frame is replicated
//       into the whole window, so every accepted sample emits a median and
//       short frames keep their last flag.
//
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     in_valid/in_ready    : input handshake
//     in_data, in_last     : input sample and end-of-frame flag
//     out_valid/out_ready  : output handshake
//     out_data, out_last   : registered median and its end-of-frame flag
//     out_count            : completed output handshakes, wraps
module median3_stream_filter
  import median3_stream_filter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_count
);

  fill_t fill;
  fill_t fill_next;

  logic [DATA_W-1:0] w0;
  logic [DATA_W-1:0] w1;
  logic [DATA_W-1:0] w2;

  logic              accept;
  logic              out_hs;
  logic              emit;
  logic              replicate;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_c;
  logic [DATA_W-1:0] med;

  // Single output register, no skid buffer: a new sample may enter only
  // when the output slot is free or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= FILL_EMPTY;
    end else begin
      fill <= fill_next;
    end
  end

  always_comb begin
    fill_next = fill;
    emit      = 1'b0;
    replicate = 1'b0;
    if (accept) begin
      unique case (fill)
        FILL_EMPTY: begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
          fill_next = FILL_FULL;
          emit      = 1'b1;
          replicate = 1'b1;
`else
          fill_next = FILL_ONE;
`endif
        end
        FILL_ONE: begin
          fill_next = FILL_TWO;
        end
        FILL_TWO: begin
          fill_next = FILL_FULL;
          emit      = 1'b1;
        end
        FILL_FULL: begin
          fill_next = FILL_FULL;
          emit      = 1'b1;
        end
        default: begin
          fill_next = FILL_EMPTY;
        end
      endcase
      // End of frame overrides the fill advance; the emit above still
      // happens so the last sample's median carries out_last.
      if (in_last) begin
        fill_next = FILL_EMPTY;
      end
    end
  end

  // When replicating, the stale window contents are ignored and the new
  // sample stands in for both history taps.
  assign op_b = replicate ? in_data : w0;
  assign op_c = replicate ? in_data : w1;

  median3_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .a  (in_data),
    .b  (op_b),
    .c  (op_c),
    .med(med)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else if (accept) begin
      if (replicate) begin
        w0 <= in_data;
        w1 <= in_data;
        w2 <= in_data;
      end else begin
        w0 <= in_data;
        w1 <= w0;
        w2 <= w1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= med;
      out_last  <= in_last;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_hs) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_median3_stream_filter.sv
// tb_median3_stream_filter
//   Self-checking bench for median3_stream_filter. Expected medians come
//   from a frame-history model (sorting arithmetic over the last three
//   samples of the current frame). Build with MEDIAN_EDGE_REPLICATE_EN
//   defined to exercise the edge-replicate variant.
module tb_median3_stream_filter;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] out_count;

  int checks   = 0;
  int failures = 0;

  smp_t in_q[$];
  smp_t exp_q[$];
  smp_t obs_q[$];

  median3_stream_filter #(
    .DATA_W(8),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic smp_t mk(input int d, input bit l);
    smp_t s;
    s.data = 8'(d);
    s.last = l;
    return s;
  endfunction

  function automatic int med3(input int a, input int b, input int c);
    int mx;
    int mn;
    mx = (a > b) ? a : b;
    mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b;
    mn = (mn < c) ? mn : c;
    return a + b + c - mx - mn;
  endfunction

  // Expected outputs for the whole of in_q: each sample, once the frame
  // history holds three values, yields the median of the newest three.
  task automatic build_expected();
    int hist[$];
    exp_q.delete();
    foreach (in_q[i]) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
      if (hist.size() == 0) begin
        hist.push_back(int'(in_q[i].data));
        hist.push_back(int'(in_q[i].data));
      end
`endif
      hist.push_back(int'(in_q[i].data));
      if (hist.size() >= 3) begin
        exp_q.push_back(mk(med3(hist[hist.size()-1], hist[hist.size()-2],
                                hist[hist.size()-3]), in_q[i].last));
      end
      if (in_q[i].last) hist.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Feeds in_q and records every output handshake into obs_q until the
  // queue is empty and the output register has drained.
  task automatic drive_stream(input bit rnd, output int acc_cycles, output int stalls);
    int guard;
    guard      = 0;
    acc_cycles = 0;
    stalls     = 0;
    obs_q.delete();
    forever begin
      @(negedge clk);
      if (in_q.size() == 0 && !out_valid) break;
      if (guard >= 4000) begin
        checks++;
        failures++;
        $display("FAIL stream_timeout: pending_in=%0d out_valid=%0b required drained", in_q.size(), out_valid);
        break;
      end
      guard++;
      if (in_q.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = in_q[0].data;
        in_last  = in_q[0].last;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        in_last  = 1'($urandom_range(0, 1));
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (in_q.size() != 0) acc_cycles++;
      if (in_valid && !in_ready) stalls++;
      if (out_valid && out_ready) obs_q.push_back(mk(int'(out_data), out_last));
      if (in_valid && in_ready) void'(in_q.pop_front());
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
    checks++; if (out_count !== 16'd0) begin failures++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_stream();
    int ac;
    int st;
    do_reset();
    in_q = '{mk(10, 0), mk(200, 0), mk(30, 0), mk(40, 1)};
`ifdef MEDIAN_EDGE_REPLICATE_EN
    exp_q = '{mk(10, 0), mk(10, 0), mk(30, 0), mk(40, 1)};
`else
    exp_q = '{mk(30, 0), mk(40, 1)};
`endif
    drive_stream(1'b0, ac, st);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_out[%0d]: got data=%0d last=%0b want data=%0d last=%0b",
                 i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++;
    if (out_count !== 16'(exp_q.size())) begin
      failures++; $display("FAIL basic_out_count: got %0d want %0d", out_count, exp_q.size());
    end
  endtask

  task automatic test_pow2_sweep();
    int ac;
    int st;
    do_reset();
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(mk(1 << i, i == 7));
    build_expected();
    drive_stream(1'b0, ac, st);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL pow2_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pow2_out[%0d]: got data=%0d last=%0b want data=%0d last=%0b",
                 i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++; if (st != 0) begin failures++; $display("FAIL pow2_stalls: got %0d want 0", st); end
    checks++; if (ac != 8) begin failures++; $display("FAIL pow2_accept_cycles: got %0d want 8", ac); end
  endtask

  task automatic test_backpressure();
    int ac;
    int st;
    int g;
    do_reset();
    in_q = '{mk(10, 0), mk(20, 0), mk(30, 0), mk(40, 0), mk(50, 1)};
    build_expected();
    out_ready = 1'b0;
    g = 0;
    forever begin
      @(negedge clk);
      if (out_valid || g >= 20) break;
      g++;
      in_valid = 1'b1;
      in_data  = in_q[0].data;
      in_last  = in_q[0].last;
      #1;
      if (in_ready) void'(in_q.pop_front());
    end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL bp_fill: out_valid=%0b want 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      in_valid  = 1'b1;
      in_data   = in_q[0].data;
      in_last   = in_q[0].last;
      out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", c, in_ready); end
      checks++; if (out_data !== exp_q[0].data) begin failures++; $display("FAIL bp_hold_data[%0d]: got %0d want %0d", c, out_data, exp_q[0].data); end
      checks++; if (out_last !== exp_q[0].last) begin failures++; $display("FAIL bp_hold_last[%0d]: got %0b want %0b", c, out_last, exp_q[0].last); end
    end
    drive_stream(1'b0, ac, st);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_out[%0d]: got data=%0d last=%0b want data=%0d last=%0b",
                 i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_frame_boundary();
    int ac;
    int st;
    do_reset();
    in_q = '{mk(5, 0), mk(9, 0), mk(7, 1), mk(1, 0), mk(3, 0), mk(2, 1)};
    build_expected();
    drive_stream(1'b0, ac, st);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL frame_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL frame_out[%0d]: got data=%0d last=%0b want data=%0d last=%0b",
                 i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int ac;
    int st;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'd50 : 8'd60;
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_count !== 16'd0) begin failures++; $display("FAIL midrst_out_count0: got %0d want 0", out_count); end
    in_q = '{mk(1, 0), mk(2, 0), mk(3, 1)};
`ifdef MEDIAN_EDGE_REPLICATE_EN
    exp_q = '{mk(1, 0), mk(1, 0), mk(2, 1)};
`else
    exp_q = '{mk(2, 1)};
`endif
    drive_stream(1'b0, ac, st);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL midrst_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midrst_out[%0d]: got data=%0d last=%0b want data=%0d last=%0b",
                 i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++;
    if (out_count !== 16'(exp_q.size())) begin
      failures++; $display("FAIL midrst_out_count: got %0d want %0d", out_count, exp_q.size());
    end
  endtask

  task automatic test_random();
    int ac;
    int st;
    int len;
    int hi;
    logic [15:0] cnt0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      hi = (r % 2 == 0) ? 255 : 3;
      in_q.delete();
      for (int f = 0; f < 10; f++) begin
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) in_q.push_back(mk($urandom_range(0, hi), k == len - 1));
      end
      build_expected();
      cnt0 = out_count;
      drive_stream(1'b1, ac, st);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count: got %0d outputs want %0d", r, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_out[%0d]: got data=%0d last=%0b want data=%0d last=%0b",
                   r, i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last);
        end
      end
      checks++;
      if (out_count !== 16'(cnt0 + 16'(exp_q.size()))) begin
        failures++; $display("FAIL rand%0d_out_count: got %0d want %0d", r, out_count, 16'(cnt0 + 16'(exp_q.size())));
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_stream();
    test_pow2_sweep();
    test_backpressure();
    test_frame_boundary();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
